// File: rtl/keypad_emulator.sv
// keypad_emulator
// Emulates one key of a 4x4 matrix keypad. A press request starts an
// optional contact-bounce phase, holds the contact closed, then opens it
// for a release period before signalling completion. The row lines are a
// combinational function of the scanner's column drive, so a scanner sees
// the closed contact with zero clock latency.
module keypad_emulator #(
    parameter int unsigned PRESS_CYC   = 64,  // closed cycles after bounce, 1..65535
    parameter int unsigned RELEASE_CYC = 16,  // open cycles before completion, 1..65535
    parameter int unsigned BOUNCE_CYC  = 4    // bounce cycles at press start, 0..255
) (
    input  logic       clk,
    input  logic       reset,      // asynchronous, active-low
    input  logic [3:0] col,        // active-low column drive from scanner
    output logic [3:0] row,        // active-low row lines back to scanner
    input  logic       key_req,    // press request, only honoured when idle
    input  logic [3:0] key_code,   // [3:2] column index, [1:0] row index
    input  logic       bounce_en,  // request a bounce phase for this press
    output logic       busy,
    output logic       done,
    output logic       contact
);

    // Phase counters are 16 bits so the longest legal phase (65535 cycles)
    // fits; the counter only ever reaches phase length minus one.
    localparam int unsigned CNT_W = 16;

    // Terminal counts: a phase of N cycles ends when the counter reads N-1.
    // BOUNCE_LAST is meaningless when BOUNCE_CYC is zero, but the bounce
    // state is never entered in that case.
    localparam logic [CNT_W-1:0] PRESS_LAST   = CNT_W'(PRESS_CYC - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYC - 1);
    localparam logic [CNT_W-1:0] BOUNCE_LAST  = CNT_W'(BOUNCE_CYC - 1);
    localparam logic             BOUNCE_ON    = (BOUNCE_CYC > 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BOUNCE  = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             contact_q, contact_d;
    logic             done_q,    done_d;
    logic [3:0]       key_q,     key_d;
    logic             bounce_q,  bounce_d;

    logic [1:0]       key_col;
    logic [1:0]       key_row;
    logic             col_driven;

    // State, counter, contact and latched request registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            contact_q <= 1'b0;
            done_q    <= 1'b0;
            key_q     <= 4'b0000;
            bounce_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            contact_q <= contact_d;
            done_q    <= done_d;
            key_q     <= key_d;
            bounce_q  <= bounce_d;
        end
    end

    // Next-state logic. contact_d is the contact value for the next cycle,
    // so contact is always a clean register output aligned with the state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        contact_d = contact_q;
        done_d    = 1'b0;
        key_d     = key_q;
        bounce_d  = bounce_q;

        case (state_q)
            IDLE: begin
                contact_d = 1'b0;
                cnt_d     = '0;
                if (key_req) begin
                    // Request and its options are latched once here and
                    // are not looked at again until the sequence ends.
                    key_d     = key_code;
                    bounce_d  = bounce_en;
                    contact_d = 1'b1;
                    if (bounce_en && BOUNCE_ON) begin
                        state_d = BOUNCE;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end

            BOUNCE: begin
                if (cnt_q == BOUNCE_LAST) begin
                    state_d   = HOLD;
                    cnt_d     = '0;
                    contact_d = 1'b1;
                end else begin
                    // Contact starts closed on entry and flips every cycle.
                    cnt_d     = cnt_q + 1'b1;
                    contact_d = ~contact_q;
                end
            end

            HOLD: begin
                if (cnt_q == PRESS_LAST) begin
                    state_d   = RELEASE;
                    cnt_d     = '0;
                    contact_d = 1'b0;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    contact_d = 1'b1;
                end
            end

            RELEASE: begin
                contact_d = 1'b0;
                if (cnt_q == RELEASE_LAST) begin
                    // Completion is flagged in the first idle cycle, during
                    // which a new request is already accepted.
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                contact_d = 1'b0;
            end
        endcase
    end

    // Split the latched key into its column and row indices and see whether
    // the scanner is currently driving the pressed key's column.
    assign key_col    = key_q[3:2];
    assign key_row    = key_q[1:0];
    assign col_driven = ~col[key_col];

    // Row lines: only the pressed key's row is pulled low, and only while
    // the contact is closed and its column is driven. Any other column bits
    // being driven at the same time do not matter.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_row
            assign row[gi] = ~(contact_q & col_driven & (key_row == 2'(gi)));
        end
    endgenerate

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign contact = contact_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed testbench for keypad_emulator with default parameters
// (PRESS_CYC=64, RELEASE_CYC=16, BOUNCE_CYC=4). Inputs change and outputs
// are sampled on the falling clock edge; "cycle T+i" is the i-th cycle
// after the cycle in which key_req was high.
module tb_keypad_emulator;

    logic       clk;
    logic       reset;
    logic [3:0] col;
    logic [3:0] row;
    logic       key_req;
    logic [3:0] key_code;
    logic       bounce_en;
    logic       busy;
    logic       done;
    logic       contact;

    int n_vec;
    int n_miss;

    keypad_emulator dut (
        .clk       (clk),
        .reset     (reset),
        .col       (col),
        .row       (row),
        .key_req   (key_req),
        .key_code  (key_code),
        .bounce_en (bounce_en),
        .busy      (busy),
        .done      (done),
        .contact   (contact)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reset drives everything idle, asynchronously, and idle persists.
    task automatic test_reset();
        @(negedge clk);
        col = 4'b0000;
        #1;
        n_vec++;
        if ({busy, contact, done} !== 3'b000) begin
            n_miss++;
            $display("FAIL reset_flags got busy/contact/done=%b want=000", {busy, contact, done});
        end
        n_vec++;
        if (row !== 4'b1111) begin
            n_miss++;
            $display("FAIL reset_row got=%b want=1111", row);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({busy, contact, done, row} !== 7'b000_1111) begin
            n_miss++;
            $display("FAIL reset_release got=%b want=0001111", {busy, contact, done, row});
        end
        $display("reset applied and released");
    endtask

    // Plain press of key c=1,r=0 without bounce.
    task automatic test_basic();
        logic [2:0] exp_f;
        logic [3:0] exp_r;
        @(negedge clk);
        key_code = 4'b0100; bounce_en = 1'b0; key_req = 1'b1;
        @(negedge clk);
        key_req = 1'b0;
        $display("press key=4 bounce=0");
        for (int i = 1; i <= 82; i++) begin
            exp_f = (i <= 64) ? 3'b110 : (i <= 80) ? 3'b100 : (i == 81) ? 3'b001 : 3'b000;
            n_vec++;
            if ({busy, contact, done} !== exp_f) begin
                n_miss++;
                $display("FAIL basic_flags T+%0d got busy/contact/done=%b want=%b", i, {busy, contact, done}, exp_f);
            end
            col = 4'b1101; #1;
            exp_r = (i <= 64) ? 4'b1110 : 4'b1111;
            n_vec++;
            if (row !== exp_r) begin
                n_miss++;
                $display("FAIL basic_row_col1 T+%0d got=%b want=%b", i, row, exp_r);
            end
            if (i == 1 || i == 70) begin
                col = 4'b1110; #1;
                n_vec++;
                if (row !== 4'b1111) begin
                    n_miss++;
                    $display("FAIL basic_row_col0 T+%0d got=%b want=1111", i, row);
                end
                col = 4'b0000; #1;
                exp_r = (i == 1) ? 4'b1110 : 4'b1111;
                n_vec++;
                if (row !== exp_r) begin
                    n_miss++;
                    $display("FAIL basic_row_allcols T+%0d got=%b want=%b", i, row, exp_r);
                end
            end
            @(negedge clk);
        end
    endtask

    // Press with bounce: 1,0,1,0 then 64 closed, 16 open, done at T+85.
    task automatic test_bounce();
        logic [2:0] exp_f;
        logic       exp_c;
        @(negedge clk);
        key_code = 4'b1011; bounce_en = 1'b1; key_req = 1'b1;
        col = 4'b1011;
        @(negedge clk);
        key_req = 1'b0; bounce_en = 1'b0;
        $display("press key=b bounce=1");
        for (int i = 1; i <= 86; i++) begin
            if (i <= 4)       exp_c = (i % 2 == 1);
            else if (i <= 68) exp_c = 1'b1;
            else              exp_c = 1'b0;
            exp_f = {(i <= 84), exp_c, (i == 85)};
            n_vec++;
            if ({busy, contact, done} !== exp_f) begin
                n_miss++;
                $display("FAIL bounce_flags T+%0d got busy/contact/done=%b want=%b", i, {busy, contact, done}, exp_f);
            end
            if (i <= 6) begin
                #1;
                n_vec++;
                if (row !== (exp_c ? 4'b0111 : 4'b1111)) begin
                    n_miss++;
                    $display("FAIL bounce_row T+%0d got=%b want=%b", i, row, exp_c ? 4'b0111 : 4'b1111);
                end
            end
            @(negedge clk);
        end
    endtask

    // Every key code, probed with each single-column drive while held.
    task automatic test_all_keys();
        logic [3:0] exp_r;
        logic [3:0] k;
        for (int kk = 0; kk < 16; kk++) begin
            k = 4'(kk);
            @(negedge clk);
            key_code = k; bounce_en = 1'b0; key_req = 1'b1;
            @(negedge clk);
            key_req = 1'b0;
            @(negedge clk);  // T+2, contact closed
            for (int c = 0; c < 4; c++) begin
                col = ~(4'b0001 << c); #1;
                exp_r = (2'(c) == k[3:2]) ? ~(4'b0001 << k[1:0]) : 4'b1111;
                n_vec++;
                if (row !== exp_r) begin
                    n_miss++;
                    $display("FAIL allkeys_row key=%h col=%0d got=%b want=%b", k, c, row, exp_r);
                end
            end
            for (int i = 3; i <= 81; i++) begin
                @(negedge clk);
                if (i == 80 || i == 81) begin
                    n_vec++;
                    if (done !== (i == 81)) begin
                        n_miss++;
                        $display("FAIL allkeys_done key=%h T+%0d got=%b want=%b", k, i, done, (i == 81));
                    end
                end
            end
            col = 4'b0000; #1;
            n_vec++;
            if (row !== 4'b1111) begin
                n_miss++;
                $display("FAIL allkeys_released key=%h got=%b want=1111", k, row);
            end
            $display("press key=%h row check done", k);
        end
    endtask

    // A second request during HOLD must not disturb the first key.
    task automatic test_lockout();
        int dones;
        dones = 0;
        @(negedge clk);
        key_code = 4'b0100; bounce_en = 1'b0; key_req = 1'b1;
        @(negedge clk);
        key_req = 1'b0;
        $display("press key=4 with interfering request key=f");
        for (int i = 1; i <= 100; i++) begin
            if (i == 10) begin key_req = 1'b1; key_code = 4'b1111; bounce_en = 1'b1; end
            if (i == 11) begin key_req = 1'b0; end
            if (done === 1'b1) dones++;
            if (i == 20) begin
                col = 4'b1101; #1;
                n_vec++;
                if (row !== 4'b1110) begin
                    n_miss++;
                    $display("FAIL lockout_row_first got=%b want=1110", row);
                end
                col = 4'b0111; #1;
                n_vec++;
                if (row !== 4'b1111) begin
                    n_miss++;
                    $display("FAIL lockout_row_second got=%b want=1111", row);
                end
            end
            if (i == 64 || i == 65 || i == 81) begin
                n_vec++;
                if ({busy, contact, done} !== ((i == 64) ? 3'b110 : (i == 65) ? 3'b100 : 3'b001)) begin
                    n_miss++;
                    $display("FAIL lockout_timing T+%0d got=%b", i, {busy, contact, done});
                end
            end
            @(negedge clk);
        end
        n_vec++;
        if (dones != 1) begin
            n_miss++;
            $display("FAIL lockout_done_count got=%0d want=1", dones);
        end
    endtask

    // key_req held high: the second press starts in the done cycle.
    task automatic test_back_to_back();
        logic [2:0] exp_f;
        @(negedge clk);
        key_code = 4'b0000; bounce_en = 1'b0; key_req = 1'b1;
        @(negedge clk);
        $display("press key=0 with key_req held high");
        for (int i = 1; i <= 163; i++) begin
            exp_f = {!(i == 81 || i == 162 || i == 163),
                     (i <= 64) || (i >= 82 && i <= 145),
                     (i == 81 || i == 162)};
            n_vec++;
            if ({busy, contact, done} !== exp_f) begin
                n_miss++;
                $display("FAIL b2b_flags T+%0d got busy/contact/done=%b want=%b", i, {busy, contact, done}, exp_f);
            end
            if (i == 162) key_req = 1'b0;
            @(negedge clk);
        end
    endtask

    // Reset mid-HOLD aborts immediately; a later press runs normally.
    task automatic test_reset_mid_hold();
        logic [2:0] exp_f;
        @(negedge clk);
        key_code = 4'b0110; bounce_en = 1'b0; key_req = 1'b1;
        @(negedge clk);
        key_req = 1'b0;
        col = 4'b1101;
        $display("press key=6 then reset in hold");
        repeat (19) @(negedge clk);  // T+20
        #1;
        n_vec++;
        if (row !== 4'b1011) begin
            n_miss++;
            $display("FAIL rst_hold_row_before got=%b want=1011", row);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if ({busy, contact, done, row} !== 7'b000_1111) begin
            n_miss++;
            $display("FAIL rst_hold_abort got=%b want=0001111", {busy, contact, done, row});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (done !== 1'b0) begin
                n_miss++;
                $display("FAIL rst_hold_no_done got=%b want=0", done);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        key_code = 4'b0110; key_req = 1'b1;
        @(negedge clk);
        key_req = 1'b0;
        $display("press key=6 after reset");
        for (int i = 1; i <= 82; i++) begin
            exp_f = (i <= 64) ? 3'b110 : (i <= 80) ? 3'b100 : (i == 81) ? 3'b001 : 3'b000;
            n_vec++;
            if ({busy, contact, done} !== exp_f) begin
                n_miss++;
                $display("FAIL rst_hold_resume T+%0d got=%b want=%b", i, {busy, contact, done}, exp_f);
            end
            if (i == 30) begin
                #1;
                n_vec++;
                if (row !== 4'b1011) begin
                    n_miss++;
                    $display("FAIL rst_hold_resume_row got=%b want=1011", row);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        reset     = 1'b0;
        col       = 4'b1111;
        key_req   = 1'b0;
        key_code  = 4'b0000;
        bounce_en = 1'b0;

        test_reset();
        test_basic();
        test_bounce();
        test_all_keys();
        test_lockout();
        test_back_to_back();
        test_reset_mid_hold();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 SHALL have parameter PRESS_CYC, default 64, number of cycles contact is held closed after bounce (legal range 1..65535).
REQ-002 SHALL have parameter RELEASE_CYC, default 16, number of cycles contact is held open before completion (legal range 1..65535).
REQ-003 SHALL have parameter BOUNCE_CYC, default 4, number of bounce cycles at press start (legal range 0..255).
REQ-004 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port col, input, 4, column drive from scanner, active-low; col[c]=0 means column c is driven.
REQ-007 SHALL have port row, output, 4, row lines to scanner, active-low; 4'b1111 means no contact.
REQ-008 SHALL have port key_req, input, 1, press request, sampled only in IDLE.
REQ-009 SHALL have port key_code, input, 4, key to press: [3:2] column index c, [1:0] row index r.
REQ-010 SHALL have port bounce_en, input, 1, enables bounce phase for this press; sampled with key_req.
REQ-011 SHALL have port busy, output, 1, high while a press/release sequence is in progress.
REQ-012 SHALL have port done, output, 1, one-cycle pulse on sequence completion.
REQ-013 SHALL have port contact, output, 1, registered contact-closed state.

Function
REQ-014 SHALL implement FSM states IDLE, BOUNCE, HOLD, RELEASE.
REQ-015 SHALL, in IDLE with key_req=1, latch key_code and bounce_en at that edge and move to BOUNCE if latched bounce_en=1 and BOUNCE_CYC>0, otherwise to HOLD.
REQ-016 SHALL, in BOUNCE, hold contact=1 on the first cycle and toggle contact every cycle thereafter, for exactly BOUNCE_CYC cycles, then move to HOLD.
REQ-017 SHALL, in HOLD, hold contact=1 for exactly PRESS_CYC cycles, then move to RELEASE.
REQ-018 SHALL, in RELEASE, hold contact=0 for exactly RELEASE_CYC cycles, then move to IDLE.
REQ-019 SHALL assert done for exactly the first IDLE cycle after RELEASE; key_req in that same cycle SHALL be accepted.
REQ-020 SHALL drive busy=1 in BOUNCE, HOLD and RELEASE, and busy=0 in IDLE.
REQ-021 SHALL ignore key_req, key_code and bounce_en while busy=1; the latched key is not altered mid-sequence.
REQ-022 SHALL compute row combinationally from col and the registered contact/latched key: row[r]=0 iff contact=1 and col[c]=0; every other row bit is 1. There is zero clock latency from col to row.
REQ-023 SHALL pull row[r] low for any col pattern with col[c]=0, including col=4'b0000.
REQ-024 SHALL drive row=4'b1111 whenever contact=0, regardless of col.
REQ-025 SHALL use phase counters wide enough for 65535 with no wrap; each phase count restarts at state entry.
REQ-026 SHALL accept all 16 key_code values as valid.

Reset
REQ-027 SHALL, on reset low, asynchronously force state=IDLE, contact=0, busy=0, done=0, latched key=4'b0000, latched bounce_en=0, counters=0, and therefore row=4'b1111.
REQ-028 SHALL abort any in-progress sequence on reset, without a done pulse; operation resumes in IDLE on the first edge after reset release.

Verification
REQ-029 Basic press: bounce_en=0, key_code=4'b0100, key_req pulse at T -> contact=1 and busy=1 from T+1 for 64 cycles; with col=4'b1101, row=4'b1110; with col=4'b1110, row=4'b1111; then 16 cycles of row=4'b1111; done=1 at cycle T+81 only.
REQ-030 Bounce: bounce_en=1, BOUNCE_CYC=4 -> contact sequence 1,0,1,0 for cycles T+1..T+4, then 1 for 64 cycles; done at T+85.
REQ-031 Scanner loop: connect to the existing keypad scanner and press every defined key code -> the scanner's key_value matches its decode table for the pressed column/row and returns to 0 after release.
REQ-032 Busy lockout: second key_req with a different key_code during HOLD -> ignored, row still reflects the first key, exactly one done pulse.
REQ-033 Back-to-back: key_req held high continuously -> new sequence starts in the done cycle; busy low for that single cycle only.
REQ-034 Reset mid-HOLD: reset asserted -> row=4'b1111, busy=0, contact=0 immediately; no done pulse; a new key_req after reset release gives a full normal sequence.
